cache_line_data_array: RTL and testbench
========================================

Name: cache_line_data_array

Overview:
- Parametrised direct-mapped cache data store. Each line holds WORDS_PER_LINE words.
- Supports word-granular CPU writes, whole-line reads with registered 1-cycle latency, and a burst refill port with a valid/ready handshake fed by the memory-side controller.
- Contents are cleared after reset by a hardware sweep instead of a single-cycle flush.
- Sits between the cache controller (read/write/refill sequencing) and the tag store.

Parameters:
- INDEX_W, 10, line index width; depth = 2**INDEX_W lines.
- WORD_W, 32, word width in bits.
- WORDS_PER_LINE, 4, words per line; power of 2, >= 2. Derived: LINE_W = WORD_W*WORDS_PER_LINE, SEL_W = clog2(WORDS_PER_LINE).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset; synchronous, active-low.
- ready  output  1  high when idle and accepting rd_en/wr_en/refill_start.
- rd_en  input  1  line read request.
- rd_index  input  INDEX_W  line to read.
- rd_data  output  LINE_W  registered line data; word 0 at LSBs.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- wr_en  input  1  single-word write.
- wr_index  input  INDEX_W  line to write.
- wr_sel  input  SEL_W  word within line.
- wr_word  input  WORD_W  write data.
- refill_start  input  1  begin line refill.
- refill_index  input  INDEX_W  line to refill.
- refill_valid  input  1  refill beat valid.
- refill_data  input  WORD_W  refill beat data; beat k lands in word k.
- refill_ready  output  1  beat accepted when refill_valid && refill_ready.
- refill_done  output  1  one-cycle pulse after the last beat is written.

Behaviour:
- FSM states: INIT, IDLE, REFILL.
- Reset (rst==0 at posedge):
  - state=INIT, sweep_cnt=0, beat_cnt=0.
  - ready=0, rd_valid=0, rd_data=0, refill_ready=0, refill_done=0.
  - Applies from any state; an in-progress refill is aborted.
- INIT:
  - Each cycle writes 0 to line sweep_cnt and increments sweep_cnt.
  - After line 2**INDEX_W-1 is written, goes to IDLE; ready=1 from the next cycle.
  - INIT lasts exactly 2**INDEX_W cycles after rst deasserts.
  - All requests are ignored during INIT.
- IDLE, read:
  - rd_en sampled at edge N gives rd_data=line[rd_index] and rd_valid=1 at edge N+1.
  - rd_valid is 0 in every other cycle.
  - rd_data holds its last value when rd_valid=0.
- IDLE, write: wr_en writes wr_word to word wr_sel of line wr_index; other words are unchanged.
- Read and write to the same index in the same cycle: the read returns pre-write data (read-before-write).
- IDLE, refill_start:
  - Latch refill_index, beat_cnt=0, go to REFILL.
  - ready=0 and refill_ready=1 from the next cycle.
  - A wr_en in the same cycle is still performed.
  - An rd_en in the same cycle is still served.
- REFILL:
  - Each handshake writes refill_data to word beat_cnt of the latched line; beat_cnt increments.
  - Stall cycles (refill_valid=0) hold all state.
  - On the handshake with beat_cnt==WORDS_PER_LINE-1: next cycle refill_ready=0, refill_done=1 for 1 cycle, ready=1, state=IDLE.
  - rd_en, wr_en and refill_start are ignored during REFILL.
- Requests while ready=0 are dropped, not queued. The controller must hold off.
- Counters wrap only via the explicit transitions above. No partial-line commit is undone on reset abort; the INIT sweep overwrites it.

Optional Feature:
- Macro: CLDA_WRITE_BYPASS_EN.
- Defined: rd_en and wr_en to the same index in the same cycle make rd_data return the line with the written word merged in (write-through bypass). Other words come from the array.
- Undefined: read-before-write, as in Behaviour.
- Refill is never bypassed, because reads are blocked during REFILL.

Test Plan:
- Reset then idle, with INDEX_W=4: ready rises exactly 16 cycles after rst goes 1. A read of line 7 returns 0 with rd_valid 1 cycle after rd_en.
- Word write/read: write 32'hDEADBEEF to line 3 word 2, then read line 3. rd_data = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}; rd_valid is a single pulse.
- Refill with stalls: refill_start on line 5, beats 11,22,33,44 with refill_valid low for 2 cycles between beats 2 and 3. refill_done pulses once after beat 4, and line 5 reads {44,33,22,11}. rd_en during the refill gives no rd_valid.
- Same-cycle read+write on line 9 word 0 with 32'h1234, line previously 0. Without the macro, rd_data word0=0. With CLDA_WRITE_BYPASS_EN, word0=32'h1234. A later read returns 32'h1234 in both builds.
- Reset mid-refill after 2 beats: refill_ready=0 on the next cycle and INIT restarts. After INIT, the refilled line reads all-zero and refill_done never pulsed.

Source files
------------

// File: rtl/cache_line_data_array.sv
// cache_line_data_array: direct-mapped cache data store with word writes, 1-cycle line reads, burst refill and a post-reset clearing sweep; define CLDA_WRITE_BYPASS_EN to merge a same-cycle write into the read result
module cache_line_data_array #(
  parameter int INDEX_W = 10,
  parameter int WORD_W = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int LINE_W = WORD_W * WORDS_PER_LINE,
  localparam int SEL_W = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              rd_en,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [LINE_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              refill_start,
  input  logic [INDEX_W-1:0] refill_index,
  input  logic              refill_valid,
  input  logic [WORD_W-1:0] refill_data,
  output logic              refill_ready,
  output logic              refill_done
);
  typedef enum logic [1:0] {INIT, IDLE, REFILL} state_t;
  state_t state, nextState;
  logic [WORD_W-1:0] mem [2**INDEX_W][WORDS_PER_LINE];
  logic [INDEX_W-1:0] sweepCnt, refIdx;
  logic [SEL_W-1:0] beatCnt;
  logic [LINE_W-1:0] rdLine;
  logic lastBeat;
  assign ready = state == IDLE;
  assign refill_ready = state == REFILL;
  assign lastBeat = state == REFILL && refill_valid && &beatCnt;
  // next state: sweep ends on the last line, refill ends on the last accepted beat
  always_comb begin
    nextState = state;
    nextState = state == INIT ? (&sweepCnt ? IDLE : INIT)
              : state == IDLE ? (refill_start ? REFILL : IDLE)
              : (lastBeat ? IDLE : REFILL);
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= INIT;
    else state <= nextState;
  end
  // sweep and beat counters plus the latched refill line
  always_ff @(posedge clk) begin
    if (!rst) begin
      sweepCnt <= '0;
      beatCnt <= '0;
      refIdx <= '0;
    end else begin
      if (state == INIT) sweepCnt <= sweepCnt + INDEX_W'(1);
      if (state == IDLE && refill_start) begin
        beatCnt <= '0;
        refIdx <= refill_index;
      end
      if (state == REFILL && refill_valid) beatCnt <= beatCnt + SEL_W'(1);
    end
  end
  // array writes: clearing sweep, CPU word write, refill beat; none while in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) for (int w = 0; w < WORDS_PER_LINE; w++) mem[sweepCnt][w] <= '0;
      else if (state == IDLE && wr_en) mem[wr_index][wr_sel] <= wr_word;
      else if (state == REFILL && refill_valid) mem[refIdx][beatCnt] <= refill_data;
    end
  end
  // assemble the addressed line, word 0 at the LSBs
  always_comb begin
    rdLine = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
`ifdef CLDA_WRITE_BYPASS_EN
      rdLine[w*WORD_W +: WORD_W] = (wr_en && wr_index == rd_index && wr_sel == SEL_W'(w))
                                   ? wr_word : mem[rd_index][w];
`else
      rdLine[w*WORD_W +: WORD_W] = mem[rd_index][w];
`endif
    end
  end
  // registered read result and refill completion pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
      refill_done <= 1'b0;
    end else begin
      rd_valid <= state == IDLE && rd_en;
      if (state == IDLE && rd_en) rd_data <= rdLine;
      refill_done <= lastBeat;
    end
  end
endmodule

// File: tb/tb_cache_line_data_array.sv
// tb_cache_line_data_array: directed table and sequence checks of the cache line data array
module tb_cache_line_data_array;
`ifdef CLDA_WRITE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic ready, rd_en = 0, rd_valid, wr_en = 0, refill_start = 0, refill_valid = 0, refill_ready, refill_done;
  logic [3:0] rd_index = 0, wr_index = 0, refill_index = 0;
  logic [1:0] wr_sel = 0;
  logic [31:0] wr_word = 0, refill_data = 0;
  logic [127:0] rd_data;
  int n = 0, errs = 0;
  typedef struct {
    logic rd; logic [3:0] ri; logic wr; logic [3:0] wi; logic [1:0] ws; logic [31:0] ww;
    logic ev; logic [127:0] ed;
  } vec_t;
  vec_t tbl[10];
  cache_line_data_array #(.INDEX_W(4)) dut (
    .clk(clk), .rst(rst), .ready(ready), .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_index(wr_index), .wr_sel(wr_sel), .wr_word(wr_word),
    .refill_start(refill_start), .refill_index(refill_index), .refill_valid(refill_valid),
    .refill_data(refill_data), .refill_ready(refill_ready), .refill_done(refill_done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic waitInit(input string nm);
    int cyc;
    logic sawDone;
    cyc = 0;
    sawDone = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (refill_done) sawDone = 1;
      if (ready) begin
        cyc = i;
        break;
      end
    end
    chk({nm, " init cycles"}, 128'(cyc), 128'd16);
    chk({nm, " no refill_done"}, 128'(sawDone), 128'd0);
  endtask
  initial begin
    tbl[0] = '{1'b1, 4'd7,  1'b0, 4'd0,  2'd0, 32'h0,        1'b1, 128'h0};
    tbl[1] = '{1'b0, 4'd0,  1'b1, 4'd3,  2'd2, 32'hDEADBEEF, 1'b0, 128'h0};
    tbl[2] = '{1'b1, 4'd3,  1'b0, 4'd0,  2'd0, 32'h0,        1'b1, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
    tbl[3] = '{1'b0, 4'd0,  1'b0, 4'd0,  2'd0, 32'h0,        1'b0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
    tbl[4] = '{1'b0, 4'd0,  1'b1, 4'd3,  2'd0, 32'h11,       1'b0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
    tbl[5] = '{1'b1, 4'd3,  1'b0, 4'd0,  2'd0, 32'h0,        1'b1, {32'h0, 32'hDEADBEEF, 32'h0, 32'h11}};
    tbl[6] = '{1'b1, 4'd9,  1'b1, 4'd9,  2'd0, 32'h1234,     1'b1, BYP ? 128'h1234 : 128'h0};
    tbl[7] = '{1'b1, 4'd9,  1'b0, 4'd0,  2'd0, 32'h0,        1'b1, 128'h1234};
    tbl[8] = '{1'b0, 4'd0,  1'b1, 4'd15, 2'd3, 32'hA5A5A5A5, 1'b0, 128'h1234};
    tbl[9] = '{1'b1, 4'd15, 1'b0, 4'd0,  2'd0, 32'h0,        1'b1, {32'hA5A5A5A5, 96'h0}};
    repeat (3) tick();
    chk("reset ready", 128'(ready), 128'd0);
    chk("reset rd_valid", 128'(rd_valid), 128'd0);
    chk("reset rd_data", rd_data, 128'h0);
    chk("reset refill_ready", 128'(refill_ready), 128'd0);
    chk("reset refill_done", 128'(refill_done), 128'd0);
    rst = 1;
    waitInit("first");
    for (int i = 0; i < 10; i++) begin
      rd_en = tbl[i].rd; rd_index = tbl[i].ri;
      wr_en = tbl[i].wr; wr_index = tbl[i].wi; wr_sel = tbl[i].ws; wr_word = tbl[i].ww;
      tick();
      chk($sformatf("vec%0d rd_valid", i), 128'(rd_valid), 128'(tbl[i].ev));
      chk($sformatf("vec%0d rd_data", i), rd_data, tbl[i].ed);
    end
    wr_en = 0;
    rd_en = 1; rd_index = 3; refill_start = 1; refill_index = 5;
    tick();
    chk("refill start rd served", 128'(rd_valid), 128'd1);
    chk("refill start ready", 128'(ready), 128'd0);
    chk("refill start refill_ready", 128'(refill_ready), 128'd1);
    refill_start = 0; rd_index = 5;
    refill_valid = 1; refill_data = 11;
    tick();
    chk("refill rd ignored", 128'(rd_valid), 128'd0);
    rd_en = 0; refill_data = 22;
    tick();
    refill_valid = 0;
    repeat (2) tick();
    chk("stall refill_ready", 128'(refill_ready), 128'd1);
    chk("stall refill_done", 128'(refill_done), 128'd0);
    refill_valid = 1; refill_data = 33;
    tick();
    chk("beat3 refill_done", 128'(refill_done), 128'd0);
    refill_data = 44;
    tick();
    refill_valid = 0;
    chk("last beat refill_done", 128'(refill_done), 128'd1);
    chk("last beat refill_ready", 128'(refill_ready), 128'd0);
    chk("last beat ready", 128'(ready), 128'd1);
    rd_en = 1; rd_index = 5;
    tick();
    rd_en = 0;
    chk("refill_done pulse", 128'(refill_done), 128'd0);
    chk("refilled line", rd_data, {32'd44, 32'd33, 32'd22, 32'd11});
    tick();
    chk("rd_valid single pulse", 128'(rd_valid), 128'd0);
    refill_start = 1; refill_index = 6;
    tick();
    refill_start = 0; refill_valid = 1; refill_data = 32'hAA;
    tick();
    refill_data = 32'hBB;
    tick();
    rst = 0; refill_data = 32'hCC;
    tick();
    chk("abort refill_ready", 128'(refill_ready), 128'd0);
    chk("abort ready", 128'(ready), 128'd0);
    chk("abort refill_done", 128'(refill_done), 128'd0);
    rst = 1; refill_valid = 0;
    waitInit("abort");
    rd_en = 1; rd_index = 6;
    tick();
    rd_en = 0;
    chk("aborted line rd_valid", 128'(rd_valid), 128'd1);
    chk("aborted line zero", rd_data, 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
